serial_adder: RTL

//  Parametrised, bit-serial add/subtract unit: generalises the half-adder cell to WIDTH-bit operands.
//  A single full-adder slice plus a carry flip-flop processes one bit per clock, LSB first.

---
 rtl/serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder slice and a carry flip-flop
// process one operand bit per clock, LSB first. Operands come in through a
// valid/ready handshake and the result leaves through another.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             c_ff;
    logic [CW-1:0]    count;

    logic s_bit;
    logic c_next;

    // Full-adder slice working on the current LSBs and the stored carry.
    assign s_bit  = a_reg[0] ^ b_reg[0] ^ c_ff;
    assign c_next = (a_reg[0] & b_reg[0]) | (c_ff & (a_reg[0] ^ b_reg[0]));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake decoding from the current state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy = !in_ready;
    end

    // Operand capture, serial shifting and result publication on the final bit.
    // Subtraction is a + ~b + 1, so the carry starts at 1 for sub. The visible
    // result registers only change on the final RUN edge, so they hold their
    // last values through IDLE until the next operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            c_ff      <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        c_ff  <= sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= {s_bit, res_reg[WIDTH-1:1]};
                    c_ff    <= c_next;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        sum       <= {s_bit, res_reg[WIDTH-1:1]};
                        carry_out <= c_next;
                        overflow  <= c_next ^ c_ff;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
